load_store_unit: RTL and testbench

Multi-cycle load/store unit between the core's execute stage and `data_memory`, which only reads and writes aligned 32-bit words. The unit accepts one request at a time and converts byte and halfword accesses into word accesses. Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended. Misaligned and unsupported accesses are reported as errors and never touch memory.

---
 rtl/load_store_unit.sv | 193 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit that sits between the execute stage and a
// word-only data memory. It accepts one request at a time, turns byte and
// halfword accesses into aligned word accesses (read-modify-write for
// sub-word stores), sign/zero-extends loads and reports misaligned or
// illegal-funct3 requests as errors without touching memory.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_we            : 1 = store, 0 = load
//   req_funct3        : RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr          : byte address
//   req_wdata         : store data (low byte/halfword used for SB/SH)
//   resp_valid        : one-cycle completion pulse
//   resp_err          : error flag, qualified by resp_valid
//   resp_rdata        : extended load result, held until next response
//   mem_memrw         : memory write enable
//   mem_address       : word-aligned memory address
//   mem_data_write    : memory write data (0 when not writing)
//   mem_data_read     : combinational read data of the word at mem_address
// -----------------------------------------------------------------------------
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_memrw,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_write,
    input  logic [31:0] mem_data_read
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // funct3[1:0] encodes the access size; funct3[2] selects zero-extension.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state, next_state;

    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_bad;
    logic [31:0] word_addr;
    logic [4:0]  lane_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // Illegal encodings and misalignment. Only legal sizes reach the
    // alignment test, so the two checks never overlap in meaning.
    function automatic logic is_bad(input logic       we,
                                    input logic [2:0] f3,
                                    input logic [1:0] a);
        logic illegal;
        logic misaligned;
        if (we) illegal = (f3 == 3'b011) || f3[2];
        else    illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        misaligned = ((f3[1:0] == SIZE_HALF) && a[0]) ||
                     ((f3[1:0] == SIZE_WORD) && (a != 2'b00));
        return illegal || misaligned;
    endfunction

    assign accept     = (state == IDLE) && req_valid;
    assign req_bad    = is_bad(req_we, req_funct3, req_addr[1:0]);
    assign word_addr  = {addr_q[31:2], 2'b00};
    assign lane_shift = {addr_q[1:0], 3'b000};

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        byte_lane = mem_data_read[lane_shift +: 8];
        half_lane = addr_q[1] ? mem_data_read[31:16] : mem_data_read[15:0];
        case (funct3_q[1:0])
            SIZE_BYTE: load_data = {{24{byte_lane[7] & ~funct3_q[2]}}, byte_lane};
            SIZE_HALF: load_data = {{16{half_lane[15] & ~funct3_q[2]}}, half_lane};
            default:   load_data = mem_data_read;
        endcase
    end

    // Replace the addressed byte/halfword of the word just read.
    always_comb begin
        merge_data = mem_data_read;
        if (funct3_q[1:0] == SIZE_BYTE) begin
            merge_data[lane_shift +: 8] = wdata_q[7:0];
        end else if (addr_q[1]) begin
            merge_data[31:16] = wdata_q[15:0];
        end else begin
            merge_data[15:0] = wdata_q[15:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output and next_state gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        mem_memrw      = 1'b0;
        mem_address    = 32'd0;
        mem_data_write = 32'd0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = req_bad ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_address = word_addr;
                if (we_q && (funct3_q[1:0] == SIZE_WORD)) begin
                    mem_memrw      = 1'b1;
                    mem_data_write = wdata_q;
                    next_state     = RESP;
                end else if (we_q) begin
                    next_state = WRITE;
                end else begin
                    next_state = RESP;
                end
            end
            WRITE: begin
                mem_memrw      = 1'b1;
                mem_address    = word_addr;
                mem_data_write = merge_q;
                next_state     = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            merge_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                err_q    <= req_bad;
                if (req_bad) rdata_q <= 32'd0;
            end
            if (state == ACCESS) begin
                if (!we_q) rdata_q <= load_data;
                // Only consumed by WRITE, so capturing it for SW is harmless.
                else       merge_q <= merge_data;
            end
        end
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Self-checking bench for load_store_unit with a behavioural word memory.
// A table of directed requests (all hitting word 0x10 or an alias of it)
// checks latency, error flag, load result, write count and memory contents;
// hand-written sequences cover reset values, reset during WRITE and the
// held-valid handshake.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_memrw;
    logic [31:0] mem_address;
    logic [31:0] mem_data_write;
    logic [31:0] mem_data_read;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_err       (resp_err),
        .resp_rdata     (resp_rdata),
        .mem_memrw      (mem_memrw),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_data_read  (mem_data_read)
    );

    // Word memory decoded on address[9:2], combinational read.
    logic [31:0] mem [256] = '{default: 32'd0};
    assign mem_data_read = mem[mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_memrw) mem[mem_address[9:2]] <= mem_data_write;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;   // resp_rdata at the response
        logic [31:0] word;    // memory word 0x10 afterwards
    } vec_t;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                logic err, logic [31:0] rdata, logic [31:0] word);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.err = err; v.rdata = rdata; v.word = word;
        return v;
    endfunction

    // Issue one request and observe it to completion. Latency counts cycles
    // from the accept edge to the cycle with resp_valid high.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int writes,
                          output logic err, output logic [31:0] rdata, output logic after_rv);
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        writes = 0;
        while (!resp_valid && lat < 8) begin
            if (mem_memrw) writes++;
            @(negedge clk);
            lat++;
        end
        if (mem_memrw) writes++;
        err   = resp_err;
        rdata = resp_rdata;
        @(negedge clk);
        after_rv = resp_valid;
    endtask

    vec_t vecs[26];

    initial begin
        int          lat, writes, exp_lat, exp_wr;
        logic        err, after_rv;
        logic [31:0] rdata;
        int          accepts, resps, consec;
        logic        prev_rv;
        logic [31:0] rd0, rd1;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;

        //            we  f3      addr          wdata         err  rdata         word
        vecs[0]  = mk(1, 3'b010, 32'h10,  32'h11223344, 0, 32'h00000000, 32'h11223344);
        vecs[1]  = mk(0, 3'b010, 32'h10,  32'h0,        0, 32'h11223344, 32'h11223344);
        vecs[2]  = mk(1, 3'b000, 32'h11,  32'hDEADBEAA, 0, 32'h11223344, 32'h1122AA44);
        vecs[3]  = mk(0, 3'b010, 32'h10,  32'h0,        0, 32'h1122AA44, 32'h1122AA44);
        vecs[4]  = mk(0, 3'b000, 32'h11,  32'h0,        0, 32'hFFFFFFAA, 32'h1122AA44);
        vecs[5]  = mk(0, 3'b100, 32'h11,  32'h0,        0, 32'h000000AA, 32'h1122AA44);
        vecs[6]  = mk(0, 3'b001, 32'h12,  32'h0,        0, 32'h00001122, 32'h1122AA44);
        vecs[7]  = mk(1, 3'b001, 32'h12,  32'h00008001, 0, 32'h00001122, 32'h8001AA44);
        vecs[8]  = mk(0, 3'b001, 32'h12,  32'h0,        0, 32'hFFFF8001, 32'h8001AA44);
        vecs[9]  = mk(0, 3'b101, 32'h12,  32'h0,        0, 32'h00008001, 32'h8001AA44);
        vecs[10] = mk(0, 3'b000, 32'h13,  32'h0,        0, 32'hFFFFFF80, 32'h8001AA44);
        vecs[11] = mk(0, 3'b001, 32'h13,  32'h0,        1, 32'h00000000, 32'h8001AA44);
        vecs[12] = mk(1, 3'b010, 32'h12,  32'hCAFEF00D, 1, 32'h00000000, 32'h8001AA44);
        vecs[13] = mk(0, 3'b011, 32'h10,  32'h0,        1, 32'h00000000, 32'h8001AA44);
        vecs[14] = mk(1, 3'b100, 32'h10,  32'hCAFEF00D, 1, 32'h00000000, 32'h8001AA44);
        vecs[15] = mk(0, 3'b110, 32'h10,  32'h0,        1, 32'h00000000, 32'h8001AA44);
        vecs[16] = mk(1, 3'b111, 32'h10,  32'hCAFEF00D, 1, 32'h00000000, 32'h8001AA44);
        vecs[17] = mk(0, 3'b010, 32'h10,  32'h0,        0, 32'h8001AA44, 32'h8001AA44);
        vecs[18] = mk(1, 3'b000, 32'h10,  32'h12345655, 0, 32'h8001AA44, 32'h8001AA55);
        vecs[19] = mk(1, 3'b000, 32'h13,  32'h0000007F, 0, 32'h8001AA44, 32'h7F01AA55);
        vecs[20] = mk(0, 3'b010, 32'h410, 32'h0,        0, 32'h7F01AA55, 32'h7F01AA55);
        vecs[21] = mk(0, 3'b100, 32'h10,  32'h0,        0, 32'h00000055, 32'h7F01AA55);
        vecs[22] = mk(0, 3'b001, 32'h10,  32'h0,        0, 32'hFFFFAA55, 32'h7F01AA55);
        vecs[23] = mk(1, 3'b001, 32'h10,  32'hFFFF1234, 0, 32'hFFFFAA55, 32'h7F011234);
        vecs[24] = mk(0, 3'b010, 32'h10,  32'h0,        0, 32'h7F011234, 32'h7F011234);
        vecs[25] = mk(0, 3'b000, 32'h12,  32'h0,        0, 32'h00000001, 32'h7F011234);

        // Reset values.
        #1;
        check("reset req_ready",      {31'd0, req_ready},  32'd1);
        check("reset resp_valid",     {31'd0, resp_valid}, 32'd0);
        check("reset resp_err",       {31'd0, resp_err},   32'd0);
        check("reset resp_rdata",     resp_rdata,          32'd0);
        check("reset mem_memrw",      {31'd0, mem_memrw},  32'd0);
        check("reset mem_address",    mem_address,         32'd0);
        check("reset mem_data_write", mem_data_write,      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            exp_lat = vecs[i].err ? 1 : ((vecs[i].we && vecs[i].f3 != 3'b010) ? 3 : 2);
            exp_wr  = (!vecs[i].err && vecs[i].we) ? 1 : 0;
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   lat, writes, err, rdata, after_rv);
            check($sformatf("v%0d latency", i),    lat,              exp_lat);
            check($sformatf("v%0d resp_err", i),   {31'd0, err},     {31'd0, vecs[i].err});
            check($sformatf("v%0d resp_rdata", i), rdata,            vecs[i].rdata);
            check($sformatf("v%0d writes", i),     writes,           exp_wr);
            check($sformatf("v%0d mem word", i),   mem[4],           vecs[i].word);
            check($sformatf("v%0d pulse", i),      {31'd0, after_rv}, 32'd0);
        end

        // Reset while in WRITE of an SB: write must be suppressed.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h10; req_wdata = 32'h000000EE;
        req_valid = 1'b1;
        @(negedge clk);                       // ACCESS
        req_valid = 1'b0;
        check("rmw access memrw", {31'd0, mem_memrw}, 32'd0);
        @(negedge clk);                       // WRITE
        check("rmw write memrw", {31'd0, mem_memrw}, 32'd1);
        check("rmw write data", mem_data_write, 32'h7F0112EE);
        rst_n = 1'b0;
        #1;
        check("abort memrw drops", {31'd0, mem_memrw}, 32'd0);
        check("abort mem_address", mem_address, 32'd0);
        @(posedge clk);
        #1;
        check("abort word intact", mem[4], 32'h7F011234);
        check("abort no resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort req_ready", {31'd0, req_ready}, 32'd1);
        check("abort rdata reset", resp_rdata, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, writes, err, rdata, after_rv);
        check("post-reset LW latency", lat, 2);
        check("post-reset LW rdata", rdata, 32'h7F011234);

        // Held req_valid across two different requests.
        @(negedge clk);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
        req_valid = 1'b1;
        accepts = 0; resps = 0; consec = 0; prev_rv = 1'b0;
        rd0 = 32'h0; rd1 = 32'h0;
        for (int c = 0; c < 20 && resps < 2; c++) begin
            if (req_valid && req_ready) accepts++;
            if (resp_valid) begin
                resps++;
                if (prev_rv) consec++;
                if (resps == 1) begin
                    rd0 = resp_rdata;
                    req_funct3 = 3'b100; req_addr = 32'h12;
                end else begin
                    rd1 = resp_rdata;
                    req_valid = 1'b0;
                end
            end
            prev_rv = resp_valid;
            @(negedge clk);
        end
        check("hs accepts", accepts, 2);
        check("hs responses", resps, 2);
        check("hs consecutive rv", consec, 0);
        check("hs first rdata", rd0, 32'h7F011234);
        check("hs second rdata", rd1, 32'h00000001);
        check("hs rv after", {31'd0, resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
